// File: rtl/io_spi_master.sv
// rtl/io_spi_master.sv - mode-0 SPI master shifting one WIDTH-bit word per start request
// Optional IO_SPI_CS_GAP_EN inserts a SCLK_TIME-cycle chip-select-high GAP state after DONE.
module io_spi_master #(
  parameter int WIDTH     = 16,
  parameter int FLIP      = 0,
  parameter int SCLK_TIME = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tx,
  output logic             done_tx,
  output logic             spi_clk,
  output logic             spi_mosi,
  output logic             spi_cs,
  input  logic             spi_miso,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data
);

  localparam int TW = (SCLK_TIME > 1) ? $clog2(SCLK_TIME) : 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_DONE,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;

  logic             tmr_end;
  logic             tx_bit;
  logic [WIDTH-1:0] tx_shifted;
  logic [WIDTH-1:0] rx_shifted;

  assign tmr_end    = (tmr_q == TW'(SCLK_TIME - 1));
  assign tx_bit     = (FLIP != 0) ? tx_sh_q[0] : tx_sh_q[WIDTH-1];
  assign tx_shifted = (FLIP != 0) ? {1'b0, tx_sh_q[WIDTH-1:1]} : {tx_sh_q[WIDTH-2:0], 1'b0};
  // Received bits land in transmit order, so both directions shift the same way.
  assign rx_shifted = (FLIP != 0) ? {spi_miso, rx_sh_q[WIDTH-1:1]} : {rx_sh_q[WIDTH-2:0], spi_miso};

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    case (state_q)
      S_IDLE: begin
        if (start_tx) begin
          state_d   = S_SETUP;
          tx_sh_d   = tx_data;
          rx_sh_d   = '0;
          bit_cnt_d = '0;
          tmr_d     = '0;
        end
      end
      S_SETUP: begin
        if (tmr_end) begin
          state_d = S_HIGH;
          tmr_d   = '0;
          rx_sh_d = rx_shifted;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_HIGH: begin
        if (tmr_end) begin
          state_d   = S_LOW;
          tmr_d     = '0;
          bit_cnt_d = bit_cnt_q + CW'(1);
          // The final bit stays on mosi through the CS hold time.
          if (bit_cnt_q != CW'(WIDTH - 1)) begin
            tx_sh_d = tx_shifted;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_LOW: begin
        if (tmr_end) begin
          tmr_d = '0;
          if (bit_cnt_q == CW'(WIDTH)) begin
            state_d   = S_DONE;
            rx_data_d = rx_sh_q;
          end else begin
            state_d = S_HIGH;
            rx_sh_d = rx_shifted;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DONE: begin
`ifdef IO_SPI_CS_GAP_EN
        state_d = S_GAP;
        tmr_d   = '0;
`else
        state_d = S_IDLE;
`endif
      end
      S_GAP: begin
        if (tmr_end) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign spi_cs   = !((state_q == S_SETUP) || (state_q == S_HIGH) || (state_q == S_LOW));
  assign spi_clk  = (state_q == S_HIGH);
  assign spi_mosi = !spi_cs && tx_bit;
  assign done_tx  = (state_q == S_DONE);
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_io_spi_master.sv
// tb/tb_io_spi_master.sv - directed bench for io_spi_master: defaults instance plus FLIP=1/WIDTH=8/SCLK_TIME=1
module tb_io_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] tx0 = '0;
  logic [7:0]  tx1 = '0;
  logic        loop0 = 1'b0, loop1 = 1'b0;
  logic        done0, sclk0, mosi0, cs0, miso0;
  logic        done1, sclk1, mosi1, cs1, miso1;
  logic [15:0] rx0;
  logic [7:0]  rx1;

  int n_chk = 0;
  int n_err = 0;

  assign miso0 = loop0 ? mosi0 : 1'b0;
  assign miso1 = loop1 ? mosi1 : 1'b0;

  always #5 clk = ~clk;

  io_spi_master dut0 (
    .clk(clk), .rst(rst), .start_tx(start0), .done_tx(done0), .spi_clk(sclk0),
    .spi_mosi(mosi0), .spi_cs(cs0), .spi_miso(miso0), .tx_data(tx0), .rx_data(rx0)
  );

  io_spi_master #(.WIDTH(8), .FLIP(1), .SCLK_TIME(1)) dut1 (
    .clk(clk), .rst(rst), .start_tx(start1), .done_tx(done1), .spi_clk(sclk1),
    .spi_mosi(mosi1), .spi_cs(cs1), .spi_miso(miso1), .tx_data(tx1), .rx_data(rx1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_start(input int which, input logic v, input logic [15:0] d);
    if (which == 0) begin
      start0 = v;
      tx0    = d;
    end else begin
      start1 = v;
      tx1    = d[7:0];
    end
  endtask

  // One transaction; seq collects mosi at each spi_clk rise, first bit ending up in the MSB.
  task automatic xfer(input int which, input logic [15:0] data, input int pulse_at,
                      output logic [15:0] seq, output int cs_low, output int lat,
                      output int rises, output int dones, output logic [15:0] rx_done);
    logic        prev_clk, c_cs, c_clk, c_mosi, c_done;
    logic [15:0] c_rx;
    seq = '0; cs_low = 0; lat = -1; rises = 0; dones = 0; rx_done = '0; prev_clk = 1'b0;
    @(negedge clk);
    drive_start(which, 1'b1, data);
    @(negedge clk);
    drive_start(which, 1'b0, ~data);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      c_cs   = (which == 0) ? cs0 : cs1;
      c_clk  = (which == 0) ? sclk0 : sclk1;
      c_mosi = (which == 0) ? mosi0 : mosi1;
      c_done = (which == 0) ? done0 : done1;
      c_rx   = (which == 0) ? rx0 : {8'h00, rx1};
      if (!c_cs) cs_low++;
      if (!prev_clk && c_clk) begin
        rises++;
        seq = {seq[14:0], c_mosi};
      end
      prev_clk = c_clk;
      if (c_done) begin
        dones++;
        if (lat < 0) begin
          lat     = cyc;
          rx_done = c_rx;
        end
      end
      if (cyc == pulse_at) drive_start(which, 1'b1, 16'hFFFF);
      else if (cyc == pulse_at + 1) drive_start(which, 1'b0, ~data);
      if (lat >= 0 && cyc >= lat + 6) break;
      @(negedge clk);
    end
  endtask

  logic [15:0] seq, rxd;
  int          csl, lat, rises, dones, gap, lows;
  bit          started2;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_cs",    {31'b0, cs0},   32'd1);
    check("rst_sclk",  {31'b0, sclk0}, 32'd0);
    check("rst_mosi",  {31'b0, mosi0}, 32'd0);
    check("rst_done",  {31'b0, done0}, 32'd0);
    check("rst_rx",    {16'b0, rx0},   32'd0);
    check("rst_cs1",   {31'b0, cs1},   32'd1);
    check("rst_rx1",   {24'b0, rx1},   32'd0);

    // Single write, miso tied low
    xfer(0, 16'h0121, -10, seq, csl, lat, rises, dones, rxd);
    check("w1_mosi",  {16'b0, seq}, 32'h0121);
    check("w1_rises", rises, 32'd16);
    check("w1_cslow", csl,   32'd132);
    check("w1_lat",   lat,   32'd133);
    check("w1_dones", dones, 32'd1);
    check("w1_rx",    {16'b0, rxd}, 32'h0000);

    // Loopback
    loop0 = 1'b1;
    xfer(0, 16'hA5C3, -10, seq, csl, lat, rises, dones, rxd);
    check("lb_mosi", {16'b0, seq}, 32'hA5C3);
    check("lb_rx",   {16'b0, rxd}, 32'hA5C3);
    check("lb_lat",  lat, 32'd133);
    repeat (10) @(negedge clk);
    check("lb_hold", {16'b0, rx0}, 32'hA5C3);

    // FLIP=1, WIDTH=8, SCLK_TIME=1 loopback; 8'h01 goes out as 1,0,0,0,0,0,0,0
    loop1 = 1'b1;
    xfer(1, 16'h0001, -10, seq, csl, lat, rises, dones, rxd);
    check("f1_mosi",  {16'b0, seq}, 32'h0080);
    check("f1_rises", rises, 32'd8);
    check("f1_cslow", csl,   32'd17);
    check("f1_lat",   lat,   32'd18);
    check("f1_rx",    {16'b0, rxd}, 32'h0001);

    // Start pulses mid-transfer and during DONE are ignored
    xfer(0, 16'h1234, 50, seq, csl, lat, rises, dones, rxd);
    check("bz_mosi",  {16'b0, seq}, 32'h1234);
    check("bz_dones", dones, 32'd1);
    check("bz_cslow", csl,   32'd132);
    xfer(0, 16'h4321, 133, seq, csl, lat, rises, dones, rxd);
    check("bzd_rx",    {16'b0, rxd}, 32'h4321);
    check("bzd_dones", dones, 32'd1);
    check("bzd_cslow", csl,   32'd132);

    // start_tx held high across two words
    gap = 0; dones = 0; started2 = 1'b0;
    @(negedge clk);
    start0 = 1'b1; tx0 = 16'h00FF;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      if (done0) dones++;
      if (dones >= 1 && !started2) begin
        if (cs0) gap++;
        else begin
          started2 = 1'b1;
          start0   = 1'b0;
        end
      end
      if (dones >= 2) break;
    end
    repeat (6) begin
      @(negedge clk);
      if (done0) dones++;
    end
    check("b2b_dones", dones, 32'd2);
`ifdef IO_SPI_CS_GAP_EN
    check("b2b_gap", gap, 32'd6);
`else
    check("b2b_gap", gap, 32'd2);
`endif
    check("b2b_rx", {16'b0, rx0}, 32'h00FF);

    // Reset after the fifth bit
    rises = 0;
    @(negedge clk);
    start0 = 1'b1; tx0 = 16'h0121;
    @(negedge clk);
    start0 = 1'b0;
    for (int cyc = 0; cyc < 300 && rises < 5; cyc++) begin
      @(negedge clk);
      if (sclk0 && !cs0) begin
        rises++;
        while (sclk0) @(negedge clk);
      end
    end
    check("mr_rises", rises, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check("mr_cs",   {31'b0, cs0},   32'd1);
    check("mr_sclk", {31'b0, sclk0}, 32'd0);
    check("mr_rx",   {16'b0, rx0},   32'd0);
    rst = 1'b0;
    dones = 0; lows = 0;
    repeat (150) begin
      @(negedge clk);
      if (done0) dones++;
      if (!cs0) lows++;
    end
    check("mr_nodone", dones, 32'd0);
    check("mr_nocs",   lows,  32'd0);
    xfer(0, 16'h3C96, -10, seq, csl, lat, rises, dones, rxd);
    check("mr_after_rx",  {16'b0, rxd}, 32'h3C96);
    check("mr_after_lat", lat, 32'd133);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
